result_reader: RTL and testbench
================================

# result_reader

Drain side of the detection result FIFO. Pops the three-word records (ori_x, ori_y, candidate bitmask) that the result writer stores, one word per FIFO read. Expands each record into one detection event per set candidate bit, presented on a valid/ready stream to the overlay/HEX display stage. Sits between the result FIFO and the display logic in face_detection_system.

## Interface
- DATA_WIDTH_12, 12, FIFO word width and coordinate width
- NUM_RESIZE, 5, number of pyramid scales, which is the width of the candidate bitmask
- SCALE_WIDTH, 3, width of the scale index output; must satisfy 2^SCALE_WIDTH >= NUM_RESIZE
- DATA_WIDTH_16, 16, width of the record counter
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- fifo_data  in  DATA_WIDTH_12  result FIFO q; valid one cycle after a read
- fifo_empty  in  1  result FIFO empty flag
- o_read_result  out  1  FIFO rdreq
- o_valid  out  1  detection event valid
- i_ready  in  1  downstream accepts the event
- o_x  out  DATA_WIDTH_12  event x coordinate
- o_y  out  DATA_WIDTH_12  event y coordinate
- o_scale  out  SCALE_WIDTH  index of the set candidate bit, 0..NUM_RESIZE-1
- o_record_count  out  DATA_WIDTH_16  records fully consumed; saturates at all-ones
- o_busy  out  1  high in any state other than FETCH with word index 0

## Operation
- The FIFO word order is fixed: word 0 is ori_x, word 1 is ori_y, word 2 is the candidate, zero-extended. Bits above NUM_RESIZE-1 in word 2 are ignored.
- The FSM has three states: FETCH, CAPTURE and SCAN. There is a 2-bit word index w (0..2) and a scale index k (0..NUM_RESIZE-1).
- FETCH:
  - o_read_result = (state==FETCH) && !fifo_empty. This is combinational from the state register and fifo_empty.
  - If the read is issued, go to CAPTURE. Otherwise stay in FETCH.
- CAPTURE:
  - Latch fifo_data into slot w (x_reg, y_reg or cand_reg).
  - If w<2: w<=w+1 and return to FETCH.
  - If w==2: w<=0, k<=0, increment o_record_count with saturation, and go to SCAN.
- SCAN:
  - o_valid = (state==SCAN) && cand_reg[k]. o_x=x_reg, o_y=y_reg, o_scale=k.
  - If cand_reg[k]==0: advance k on the same cycle, with no event emitted.
  - If cand_reg[k]==1: hold all outputs stable until o_valid && i_ready, then advance k.
  - When k would advance past NUM_RESIZE-1, go to FETCH.
  - Events are emitted in ascending scale order.
- A candidate of 0 consumes NUM_RESIZE SCAN cycles and emits nothing, but still counts as a record.
- Only one FIFO read is outstanding at a time. No read is issued in CAPTURE or SCAN.
- If fifo_empty is high mid-record (w=1 or 2), the block waits in FETCH and keeps the partial record. There is no timeout.
- The block never resets or flushes the FIFO.

## Timing
- On reset, the state goes to FETCH and w=0, k=0. x_reg, y_reg and cand_reg clear to 0.
- Output values on reset: o_read_result=0, o_valid=0, o_x=0, o_y=0, o_scale=0, o_record_count=0, o_busy=0.
  - o_read_result may rise on the cycle after reset deasserts if the FIFO is not empty.
- Reset has priority over all other activity. Reset mid-record or mid-SCAN discards the partial or undrained record; no event or count is emitted for it.
- FIFO read latency is 1 cycle: data read in cycle t is latched at the end of cycle t+1.
- Minimum cost per record is 6 cycles of fetch (2 per word), then NUM_RESIZE SCAN cycles when i_ready is held high.
- First o_valid occurs no earlier than 6 cycles after the first o_read_result of the record.
- o_valid may not drop, and o_x/o_y/o_scale may not change, while o_valid && !i_ready.

## Structure
- The shared package holds:
  - the state enum (FETCH, CAPTURE, SCAN);
  - word-slot constants WORD_X=0, WORD_Y=1, WORD_CAND=2, and NUM_VARIABLE=3;
  - default widths, shared with the result writer.
- The record counter is the natural sub-module: reuse the codebase's existing counter (enable = CAPTURE with w==2). Add a saturating guard in this block. Everything else is flat.

## Test plan
- FIFO holds 100, 200, 5'b00101 with i_ready=1:
  - exactly two events, (100,200,0) then (100,200,2);
  - o_record_count=1;
  - the block returns to FETCH with o_busy=0.
- Same record with i_ready low for 4 cycles on the first event: o_valid and the outputs stay stable for those 4 cycles, then the two events are delivered in order.
- Candidate 0 record (5,6,0): no o_valid pulses, o_record_count increments, and the next record (7,8,5'b10000) emits (7,8,4).
- fifo_empty held high after word 0 (x=12) for 10 cycles, then y=34 and cand=5'b00010 are pushed: no extra reads while empty, then a single event (12,34,1).
- Reset asserted during SCAN of a 5'b11111 record after 2 events:
  - all outputs return to 0 the next cycle;
  - no further events for that record;
  - o_record_count=0.
- 3 back-to-back records, each with candidate 5'b11111 and i_ready=1: 15 events in scale order 0..4 per record, o_record_count=3, and no read is issued outside FETCH.

Source files
------------

// File: rtl/result_reader_pkg.sv
// Types and constants shared by the detection result reader and the result writer.
package result_reader_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        CAPTURE = 2'd1,
        SCAN    = 2'd2
    } state_t;

    localparam logic [1:0] WORD_X    = 2'd0;
    localparam logic [1:0] WORD_Y    = 2'd1;
    localparam logic [1:0] WORD_CAND = 2'd2;
    localparam int         NUM_VARIABLE = 3;

    localparam int DEF_DATA_WIDTH_12 = 12;
    localparam int DEF_NUM_RESIZE    = 5;
    localparam int DEF_SCALE_WIDTH   = 3;
    localparam int DEF_DATA_WIDTH_16 = 16;

endpackage

// File: rtl/result_reader_counter.sv
// Plain enable counter; callers add any saturation guard on the enable.
module result_reader_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/result_reader.sv
// Drains three-word detection records from the result FIFO and expands each
// candidate bitmask into one valid/ready event per set bit, lowest scale first.
module result_reader
    import result_reader_pkg::*;
#(
    parameter int DATA_WIDTH_12 = DEF_DATA_WIDTH_12,
    parameter int NUM_RESIZE    = DEF_NUM_RESIZE,
    parameter int SCALE_WIDTH   = DEF_SCALE_WIDTH,
    parameter int DATA_WIDTH_16 = DEF_DATA_WIDTH_16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH_12-1:0] fifo_data,
    input  logic                     fifo_empty,
    output logic                     o_read_result,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [DATA_WIDTH_12-1:0] o_x,
    output logic [DATA_WIDTH_12-1:0] o_y,
    output logic [SCALE_WIDTH-1:0]   o_scale,
    output logic [DATA_WIDTH_16-1:0] o_record_count,
    output logic                     o_busy
);

    localparam logic [1:0] WORD_LAST = 2'(NUM_VARIABLE - 1);

    state_t                   state;
    logic [1:0]               w;
    logic [SCALE_WIDTH-1:0]   k;
    logic [DATA_WIDTH_12-1:0] x_reg;
    logic [DATA_WIDTH_12-1:0] y_reg;
    logic [NUM_RESIZE-1:0]    cand_reg;
    logic [DATA_WIDTH_16-1:0] record_count;

    logic last_word;
    logic last_scale;
    logic cur_bit;
    logic advance;
    logic count_en;

    assign last_word  = (w == WORD_LAST);
    assign last_scale = (k == SCALE_WIDTH'(NUM_RESIZE - 1));
    assign cur_bit    = cand_reg[k];

    // Reset gates the read so no FIFO word is popped and then thrown away.
    assign o_read_result = !reset && (state == FETCH) && !fifo_empty;
    assign o_valid       = (state == SCAN) && cur_bit;
    assign advance       = (state == SCAN) && (!cur_bit || i_ready);
    assign count_en      = (state == CAPTURE) && last_word && (record_count != '1);

    assign o_x            = x_reg;
    assign o_y            = y_reg;
    assign o_scale        = k;
    assign o_record_count = record_count;
    assign o_busy         = !((state == FETCH) && (w == WORD_X));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            w        <= WORD_X;
            k        <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            cand_reg <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (o_read_result) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    case (w)
                        WORD_X:  x_reg    <= fifo_data;
                        WORD_Y:  y_reg    <= fifo_data;
                        default: cand_reg <= fifo_data[NUM_RESIZE-1:0];
                    endcase
                    if (last_word) begin
                        w     <= WORD_X;
                        k     <= '0;
                        state <= SCAN;
                    end else begin
                        w     <= w + 2'd1;
                        state <= FETCH;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        if (last_scale) begin
                            k     <= '0;
                            state <= FETCH;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    result_reader_counter #(
        .WIDTH (DATA_WIDTH_16)
    ) u_record_counter (
        .clk   (clk),
        .reset (reset),
        .en    (count_en),
        .count (record_count)
    );

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: FIFO model, expected-event scoreboard and a monitor.
module tb_result_reader;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [2:0]  s;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        o_read_result;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [11:0] o_x;
    logic [11:0] o_y;
    logic [2:0]  o_scale;
    logic [15:0] o_record_count;
    logic        o_busy;

    ev_t         exp_q[$];
    logic [11:0] fifo_q[$];
    int total = 0;
    int bad = 0;
    int model_cnt = 0;
    int pushed_words = 0;
    int reads = 0;
    bit rand_ready = 0;

    result_reader dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .o_read_result  (o_read_result),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_x            (o_x),
        .o_y            (o_y),
        .o_scale        (o_scale),
        .o_record_count (o_record_count),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [11:0] v);
        fifo_q.push_back(v);
        pushed_words++;
    endtask

    // Reference: one event per set bit among the low five candidate bits.
    task automatic expect_record(input logic [11:0] x, input logic [11:0] y, input logic [11:0] c);
        ev_t e;
        for (int s = 0; s < 5; s++) begin
            if (c[s]) begin
                e.x = x;
                e.y = y;
                e.s = 3'(s);
                exp_q.push_back(e);
            end
        end
        model_cnt++;
    endtask

    task automatic push_record(input logic [11:0] x, input logic [11:0] y, input logic [11:0] c);
        push_word(x);
        push_word(y);
        push_word(c);
        expect_record(x, y, c);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 400 && !(exp_q.size() == 0 && fifo_q.size() == 0 && !o_busy && !o_valid)) begin
            tick();
            n++;
        end
        check({name, " idle"}, int'(n < 400), 1);
        check({name, " count"}, int'(o_record_count), model_cnt);
        check({name, " busy"}, int'(o_busy), 0);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (n < 100 && !o_valid) begin
            tick();
            n++;
        end
        check({name, " valid seen"}, int'(n < 100), 1);
    endtask

    // FIFO model: a read seen in a cycle delivers its word just after that edge.
    initial begin
        bit rd_now;
        forever begin
            @(negedge clk);
            rd_now = o_read_result;
            @(posedge clk);
            #1;
            if (rd_now) begin
                reads++;
                total++;
                if (fifo_q.size() == 0) begin
                    bad++;
                    $display("FAIL fifo underflow: read while empty");
                end else begin
                    fifo_data = fifo_q.pop_front();
                end
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) i_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: handshakes against the scoreboard, stall stability, no reads while presenting.
    initial begin
        bit          prev_stall = 0;
        bit          prev_rst = 1;
        logic [11:0] px, py;
        logic [2:0]  ps;
        ev_t         e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev_stall && !prev_rst) begin
                    check("stall valid held", int'(o_valid), 1);
                    check("stall x held", int'(o_x), int'(px));
                    check("stall y held", int'(o_y), int'(py));
                    check("stall scale held", int'(o_scale), int'(ps));
                end
                if (o_valid) check("no read while valid", int'(o_read_result), 0);
                if (o_valid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected event", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event x", int'(o_x), int'(e.x));
                        check("event y", int'(o_y), int'(e.y));
                        check("event scale", int'(o_scale), int'(e.s));
                    end
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_rst = reset;
            px = o_x;
            py = o_y;
            ps = o_scale;
        end
    end

    initial begin
        int r0;
        repeat (3) tick();
        check("reset read", int'(o_read_result), 0);
        check("reset valid", int'(o_valid), 0);
        check("reset x", int'(o_x), 0);
        check("reset y", int'(o_y), 0);
        check("reset scale", int'(o_scale), 0);
        check("reset count", int'(o_record_count), 0);
        check("reset busy", int'(o_busy), 0);
        reset = 1'b0;
        i_ready = 1'b1;

        // basic record, two events
        push_record(12'd100, 12'd200, 12'b00101);
        wait_idle("basic");

        // first event held off for four cycles
        i_ready = 1'b0;
        push_record(12'd100, 12'd200, 12'b00101);
        wait_valid("stall");
        repeat (4) tick();
        check("stall scale after hold", int'(o_scale), 0);
        check("stall x after hold", int'(o_x), 100);
        i_ready = 1'b1;
        wait_idle("stall");

        // empty candidate still counts, next record unaffected
        push_record(12'd5, 12'd6, 12'd0);
        push_record(12'd7, 12'd8, 12'b10000);
        wait_idle("zero cand");

        // FIFO runs dry after word 0
        r0 = reads;
        push_word(12'd12);
        repeat (10) tick();
        check("partial reads", reads - r0, 1);
        check("partial busy", int'(o_busy), 1);
        check("partial no valid", int'(o_valid), 0);
        push_word(12'd34);
        push_word(12'b00010);
        expect_record(12'd12, 12'd34, 12'b00010);
        wait_idle("partial");

        // reset mid-scan after two accepted events
        i_ready = 1'b0;
        push_record(12'd300, 12'd400, 12'b11111);
        wait_valid("reset scan");
        tick();
        i_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        i_ready = 1'b0;
        tick();
        check("rst scan valid", int'(o_valid), 0);
        check("rst scan x", int'(o_x), 0);
        check("rst scan y", int'(o_y), 0);
        check("rst scan scale", int'(o_scale), 0);
        check("rst scan count", int'(o_record_count), 0);
        check("rst scan busy", int'(o_busy), 0);
        check("rst scan read", int'(o_read_result), 0);
        check("rst scan events left", exp_q.size(), 3);
        exp_q.delete();
        model_cnt = 0;
        reset = 1'b0;
        i_ready = 1'b1;
        repeat (5) tick();
        check("after rst valid", int'(o_valid), 0);

        // back-to-back full masks
        for (int i = 0; i < 3; i++) push_record(12'(i + 1), 12'(i + 50), 12'b11111);
        wait_idle("b2b");

        // random records, random ready, upper candidate bits random
        rand_ready = 1;
        for (int i = 0; i < 25; i++) begin
            push_record(12'($urandom), 12'($urandom), 12'($urandom));
            repeat ($urandom_range(0, 12)) tick();
        end
        repeat (2) tick();
        rand_ready = 0;
        i_ready = 1'b1;
        wait_idle("random");
        check("total reads", reads, pushed_words);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
